// File: rtl/magma_pkg.sv
// ============================================================================
// Module : magma_pkg
// Brief  : Shared defaults, derived round count and scheduler state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package magma_pkg;

  localparam int WORD_W     = 32;
  localparam int KEY_WORDS  = 8;
  localparam int FWD_PASSES = 3;
  localparam int ROUNDS     = (FWD_PASSES + 1) * KEY_WORDS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } ks_state_t;

endpackage

`default_nettype wire

// File: rtl/magma_rk_index.sv
// ============================================================================
// Module : magma_rk_index
// Brief  : Combinational (round, decrypt) to master-key word index mapper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module magma_rk_index #(
  parameter int KEY_WORDS  = magma_pkg::KEY_WORDS,
  parameter int FWD_PASSES = magma_pkg::FWD_PASSES,
  parameter int RND_W      = $clog2((FWD_PASSES + 1) * KEY_WORDS),
  parameter int IDX_W      = $clog2(KEY_WORDS)
) (
  input  logic [RND_W-1:0] round,
  input  logic             decrypt,
  output logic [IDX_W-1:0] idx
);

  localparam int ROUNDS = (FWD_PASSES + 1) * KEY_WORDS;

  logic [RND_W-1:0] eff_round;

  // Decrypt walks the encrypt order backwards; the final pass reverses word order.
  always_comb begin
    eff_round = decrypt ? (RND_W'(ROUNDS - 1) - round) : round;
    if (eff_round < RND_W'(FWD_PASSES * KEY_WORDS)) begin
      idx = eff_round[IDX_W-1:0];
    end else begin
      idx = ~eff_round[IDX_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/magma_key_sched.sv
// ============================================================================
// Module : magma_key_sched
// Brief  : Loadable Magma key store streaming one round key per handshake.
//          Optional MAGMA_KS_ZEROIZE_EN adds a zeroize input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module magma_key_sched
  import magma_pkg::*;
#(
  parameter int WORD_W     = magma_pkg::WORD_W,
  parameter int KEY_WORDS  = magma_pkg::KEY_WORDS,
  parameter int FWD_PASSES = magma_pkg::FWD_PASSES
) (
  input  logic                                            clk,
  input  logic                                            rst,
`ifdef MAGMA_KS_ZEROIZE_EN
  input  logic                                            zeroize,
`endif
  input  logic                                            key_valid,
  output logic                                            key_ready,
  input  logic [WORD_W-1:0]                               key_data,
  output logic                                            key_loaded,
  input  logic                                            start,
  input  logic                                            decrypt,
  input  logic                                            abort,
  output logic                                            busy,
  output logic                                            rk_valid,
  input  logic                                            rk_ready,
  output logic [WORD_W-1:0]                               rk_data,
  output logic [$clog2((FWD_PASSES+1)*KEY_WORDS)-1:0]     rk_round,
  output logic                                            rk_last
);

  localparam int N_ROUNDS = (FWD_PASSES + 1) * KEY_WORDS;
  localparam int RND_W    = $clog2(N_ROUNDS);
  localparam int IDX_W    = $clog2(KEY_WORDS);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(N_ROUNDS - 1);

  ks_state_t         state_q, state_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              loaded_q, loaded_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic              dec_q, dec_d;
  logic [WORD_W-1:0] key_q [KEY_WORDS];
  logic [WORD_W-1:0] key_d [KEY_WORDS];
  logic [WORD_W-1:0] rk_data_q, rk_data_d;
  logic              rk_last_q, rk_last_d;
  logic [IDX_W-1:0]  next_idx;
  logic              load_acc;

  magma_rk_index #(
    .KEY_WORDS  (KEY_WORDS),
    .FWD_PASSES (FWD_PASSES),
    .RND_W      (RND_W),
    .IDX_W      (IDX_W)
  ) u_rk_index (
    .round   (round_d),
    .decrypt (dec_d),
    .idx     (next_idx)
  );

  assign load_acc = key_valid && (state_q != RUN);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    loaded_d = loaded_q;
    round_d  = round_q;
    dec_d    = dec_q;
    key_d    = key_q;

    case (state_q)
      RUN: begin
        // Abort outranks a coincident handshake.
        if (abort) begin
          state_d = IDLE;
          round_d = '0;
        end else if (rk_ready) begin
          if (round_q == LAST_RND) begin
            state_d = IDLE;
            round_d = '0;
          end else begin
            round_d = round_q + RND_W'(1);
          end
        end
      end
      default: begin
        // A load word takes precedence over start: the key is about to change.
        if (load_acc) begin
          key_d[wr_ptr_q] = key_data;
          wr_ptr_d        = wr_ptr_q + IDX_W'(1);
          if (wr_ptr_q == IDX_W'(KEY_WORDS - 1)) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end else begin
            loaded_d = 1'b0;
            state_d  = EMPTY;
          end
        end else if (state_q == IDLE && wr_ptr_q == '0 && start) begin
          state_d = RUN;
          dec_d   = decrypt;
          round_d = '0;
        end
      end
    endcase

`ifdef MAGMA_KS_ZEROIZE_EN
    if (zeroize) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      loaded_d = 1'b0;
      round_d  = '0;
      dec_d    = 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_d[i] = '0;
      end
    end
`endif

    // Output registers are loaded with the key for the round about to be presented.
    rk_data_d = (state_d == RUN) ? key_q[next_idx] : '0;
    rk_last_d = (state_d == RUN) && (round_d == LAST_RND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= '0;
      loaded_q  <= 1'b0;
      round_q   <= '0;
      dec_q     <= 1'b0;
      rk_data_q <= '0;
      rk_last_q <= 1'b0;
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      loaded_q  <= loaded_d;
      round_q   <= round_d;
      dec_q     <= dec_d;
      rk_data_q <= rk_data_d;
      rk_last_q <= rk_last_d;
      key_q     <= key_d;
    end
  end

  assign key_ready  = (state_q != RUN);
  assign key_loaded = loaded_q;
  assign busy       = (state_q == RUN);
  assign rk_valid   = (state_q == RUN);
  assign rk_data    = rk_data_q;
  assign rk_round   = round_q;
  assign rk_last    = rk_last_q;

endmodule

`default_nettype wire

// File: tb/tb_magma_key_sched.sv
// ============================================================================
// Module : tb_magma_key_sched
// Brief  : Self-checking bench for magma_key_sched (honours MAGMA_KS_ZEROIZE_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_magma_key_sched;

  logic        clk;
  logic        rst;
  logic        zeroize;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key_data;
  logic        key_loaded;
  logic        start;
  logic        decrypt;
  logic        abort;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [31:0] rk_data;
  logic [4:0]  rk_round;
  logic        rk_last;

  magma_key_sched dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MAGMA_KS_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_data   (key_data),
    .key_loaded (key_loaded),
    .start      (start),
    .decrypt    (decrypt),
    .abort      (abort),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_round   (rk_round),
    .rk_last    (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] key_words [8];
  logic [31:0] cap_data [2][32];
  bit          cap_last [2][32];

  typedef struct {
    bit          dec;
    int          rnd;
    logic [31:0] data;
    bit          last;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int exp_idx(input int r, input bit dec);
    int rr;
    rr = dec ? (31 - r) : r;
    return (rr < 24) ? (rr % 8) : (7 - (rr % 8));
  endfunction

  task automatic load_words(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      key_valid = 1'b1;
      key_data  = key_words[i];
      step();
    end
    key_valid = 1'b0;
    key_data  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " key_ready"},  key_ready,  1);
    chk({tag, " key_loaded"}, key_loaded, 0);
    chk({tag, " busy"},       busy,       0);
    chk({tag, " rk_valid"},   rk_valid,   0);
    chk({tag, " rk_data"},    rk_data,    0);
    chk({tag, " rk_round"},   rk_round,   0);
    chk({tag, " rk_last"},    rk_last,    0);
  endtask

  task automatic capture(input bit dec);
    start   = 1'b1;
    decrypt = dec;
    step();
    start    = 1'b0;
    decrypt  = 1'b0;
    rk_ready = 1'b1;
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("run%0d rk_valid r%0d", dec, r), rk_valid, 1);
      chk($sformatf("run%0d rk_round r%0d", dec, r), rk_round, r);
      cap_data[dec][r] = rk_data;
      cap_last[dec][r] = rk_last;
      step();
    end
    chk($sformatf("run%0d busy after last", dec), busy, 0);
    chk($sformatf("run%0d rk_valid after last", dec), rk_valid, 0);
  endtask

  task automatic start_and_advance(input int n);
    start   = 1'b1;
    decrypt = 1'b0;
    step();
    start    = 1'b0;
    rk_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    rk_ready = 1'b1;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("drain busy", busy, 0);
  endtask

  initial begin
    int nl;

    key_words = '{32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100,
                  32'hf0f1f2f3, 32'hf4f5f6f7, 32'hf8f9fafb, 32'hfcfdfeff};

    vecs[0] = '{0,  0, 32'hffeeddcc, 0};
    vecs[1] = '{0,  7, 32'hfcfdfeff, 0};
    vecs[2] = '{0,  8, 32'hffeeddcc, 0};
    vecs[3] = '{0, 23, 32'hfcfdfeff, 0};
    vecs[4] = '{0, 24, 32'hfcfdfeff, 0};
    vecs[5] = '{0, 31, 32'hffeeddcc, 1};
    vecs[6] = '{1,  0, 32'hffeeddcc, 0};
    vecs[7] = '{1,  7, 32'hfcfdfeff, 0};
    vecs[8] = '{1,  8, 32'hfcfdfeff, 0};
    vecs[9] = '{1, 31, 32'hffeeddcc, 1};

    rst = 1'b1; zeroize = 1'b0; key_valid = 1'b0; key_data = '0;
    start = 1'b0; decrypt = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    load_words(0, 8);
    chk("key_loaded after load", key_loaded, 1);

    // Decrypt run starts in the cycle right after the encrypt run's last handshake.
    capture(1'b0);
    capture(1'b1);

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d rk_data dec%0d r%0d", i, vecs[i].dec, vecs[i].rnd),
          cap_data[vecs[i].dec][vecs[i].rnd], vecs[i].data);
      chk($sformatf("vec%0d rk_last dec%0d r%0d", i, vecs[i].dec, vecs[i].rnd),
          cap_last[vecs[i].dec][vecs[i].rnd], vecs[i].last);
    end

    for (int d = 0; d < 2; d++) begin
      nl = 0;
      for (int r = 0; r < 32; r++) begin
        chk($sformatf("model dec%0d r%0d", d, r), cap_data[d][r], key_words[exp_idx(r, d[0])]);
        nl += int'(cap_last[d][r]);
      end
      chk($sformatf("rk_last count dec%0d", d), nl, 1);
    end

    // Stall at round 5, with a start pulse during RUN that must be ignored.
    start_and_advance(5);
    rk_ready = 1'b0;
    start    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d rk_data", k), rk_data, 32'hf4f5f6f7);
      chk($sformatf("stall%0d rk_round", k), rk_round, 5);
      step();
      start = 1'b0;
    end
    chk("stall end rk_round", rk_round, 5);
    rk_ready = 1'b1;
    step();
    chk("after stall rk_round", rk_round, 6);
    chk("after stall rk_data", rk_data, 32'hf8f9fafb);
    drain();

    // Abort at round 10, coinciding with a ready consumer.
    start_and_advance(10);
    chk("pre-abort rk_round", rk_round, 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort rk_valid", rk_valid, 0);
    chk("abort key_loaded", key_loaded, 1);
    start_and_advance(0);
    chk("restart rk_round", rk_round, 0);
    chk("restart rk_data", rk_data, 32'hffeeddcc);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Partial reload then start: start ignored, key not loaded.
    load_words(0, 4);
    chk("partial key_loaded", key_loaded, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("partial start busy", busy, 0);
    chk("partial start rk_valid", rk_valid, 0);
    load_words(4, 4);
    chk("completed key_loaded", key_loaded, 1);

    // Reset mid-run.
    start_and_advance(12);
    chk("pre-rst rk_round", rk_round, 12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrun rst");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start after rst busy", busy, 0);
    load_words(0, 8);
    start_and_advance(0);
    chk("reload rk_data", rk_data, 32'hffeeddcc);
    abort = 1'b1;
    step();
    abort = 1'b0;

`ifdef MAGMA_KS_ZEROIZE_EN
    start_and_advance(12);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    check_reset_outputs("zeroize");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start after zeroize busy", busy, 0);
    load_words(0, 8);
    start_and_advance(0);
    chk("zeroize reload rk_data", rk_data, 32'hffeeddcc);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
